ram_copier: RTL and testbench

Block-move engine that is the access master for the 32×32 single-port `ram` in TOP. It accepts one command at a time: fill a range with a constant, or copy a range. It drives the RAM's `cen`/`wen`/`addr`/`din` and consumes its registered `dout`, absorbing the RAM's one-cycle read latency. It reports completion with a one-cycle `done` pulse or rejects bad commands with `err`.

---
 rtl/ram_copier.sv | 104 ++++++++++
 tb/tb_ram_copier.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copier.sv
// ram_copier: fill/copy block-move engine acting as master of a single-port RAM
// ports: start/op/src_addr/dst_addr/len/fill_data carry one command; busy/done/err report status;
//        m_cen/m_wen/m_addr/m_din drive the RAM, m_dout is the RAM's registered read data
module ram_copier #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          m_cen,
  output logic          m_wen,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout
);
  typedef enum logic [2:0] {IDLE, FILL, RD, WR, DONE, ERR} state_t;
  state_t st, nxt;
  logic [AW-1:0] src_q, dst_q, lst_q, idx, nxt_idx, nxt_addr;
  logic [DW-1:0] data_q;
  logic nxt_cen, nxt_wen, ld, last;
  // RAM controls are registered, so they are computed for the state being entered
  always_comb begin
    nxt = st;
    nxt_idx = idx;
    nxt_cen = 1'b0;
    nxt_wen = 1'b0;
    nxt_addr = '0;
    ld = 1'b0;
    last = idx == lst_q;
    case (st)
      IDLE: if (start) begin
        if (len[AW] && |len[AW-1:0]) nxt = ERR;
        else if (len == '0) nxt = DONE;
        else begin
          ld = 1'b1;
          nxt_idx = '0;
          nxt = op ? RD : FILL;
          nxt_cen = 1'b1;
          nxt_wen = !op;
          nxt_addr = op ? src_addr : dst_addr;
        end
      end
      FILL: begin
        nxt = last ? DONE : FILL;
        nxt_idx = idx + 1'b1;
        nxt_cen = !last;
        nxt_wen = !last;
        nxt_addr = last ? '0 : dst_q + idx + 1'b1;
      end
      RD: begin
        nxt = WR;
        nxt_cen = 1'b1;
        nxt_wen = 1'b1;
        nxt_addr = dst_q + idx;
      end
      WR: begin
        nxt = last ? DONE : RD;
        nxt_idx = idx + 1'b1;
        nxt_cen = !last;
        nxt_addr = last ? '0 : src_q + idx + 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      idx <= '0;
      m_cen <= 1'b0;
      m_wen <= 1'b0;
      m_addr <= '0;
      src_q <= '0;
      dst_q <= '0;
      lst_q <= '0;
      data_q <= '0;
    end else begin
      st <= nxt;
      idx <= nxt_idx;
      m_cen <= nxt_cen;
      m_wen <= nxt_wen;
      m_addr <= nxt_addr;
      if (ld) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        lst_q <= AW'(len - 1'b1);
        data_q <= fill_data;
      end
    end
  end
  assign busy = st == FILL || st == RD || st == WR;
  assign done = st == DONE;
  assign err = st == ERR;
  // RAM updates dout on the edge that ends RD, so write data must bypass any register
  assign m_din = st == WR ? m_dout : data_q;
endmodule

// File: tb/tb_ram_copier.sv
// tb_ram_copier: scoreboard bench for ram_copier with a behavioural RAM and reference model
module tb_ram_copier;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic op = 1'b0;
  logic [4:0] src_addr = '0;
  logic [4:0] dst_addr = '0;
  logic [5:0] len = '0;
  logic [31:0] fill_data = '0;
  logic busy, done, err, m_cen, m_wen;
  logic [4:0] m_addr;
  logic [31:0] m_din, m_dout;
  logic [31:0] mem [32];
  logic [31:0] mdl [32];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int cyc; bit wen; logic [4:0] addr; logic [31:0] data;} acc_t;
  typedef struct {int cyc; int kind;} ev_t;
  acc_t aq[$];
  ev_t eq[$];

  ram_copier #(.AW(5), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill_data(fill_data), .busy(busy), .done(done),
    .err(err), .m_cen(m_cen), .m_wen(m_wen), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m_cen && m_wen) mem[m_addr] <= m_din;
    m_dout <= (m_cen && !m_wen) ? mem[m_addr] : '0;
  end

  task automatic push_acc(input int c, input bit w, input int a, input logic [31:0] d);
    acc_t x;
    x.cyc = c;
    x.wen = w;
    x.addr = 5'(a % 32);
    x.data = d;
    aq.push_back(x);
  endtask

  task automatic push_ev(input int c, input int k);
    ev_t x;
    x.cyc = c;
    x.kind = k;
    eq.push_back(x);
  endtask

  // kind 1 = done, 2 = err; the model applies each command to mdl at issue time
  task automatic cmd(input bit o, input int s, input int d, input int l, input logic [31:0] fd,
                     input bit poke);
    int c0, e;
    logic [31:0] v;
    @(negedge clk);
    c0 = cyc + 1;
    if (l > 32) begin
      e = c0;
      push_ev(e, 2);
    end else if (l == 0) begin
      e = c0;
      push_ev(e, 1);
    end else if (!o) begin
      for (int k = 0; k < l; k++) begin
        mdl[(d + k) % 32] = fd;
        push_acc(c0 + k, 1'b1, d + k, fd);
      end
      e = c0 + l;
      push_ev(e, 1);
    end else begin
      for (int k = 0; k < l; k++) begin
        v = mdl[(s + k) % 32];
        push_acc(c0 + 2 * k, 1'b0, s + k, '0);
        mdl[(d + k) % 32] = v;
        push_acc(c0 + 2 * k + 1, 1'b1, d + k, v);
      end
      e = c0 + 2 * l;
      push_ev(e, 1);
    end
    op = o;
    src_addr = 5'(s);
    dst_addr = 5'(d);
    len = 6'(l);
    fill_data = fd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 2) begin
      @(negedge clk);
      if (poke) begin
        start = (cyc <= e) && cyc[0];
        op = 1'b0;
        len = 6'd5;
      end
    end
    start = 1'b0;
  endtask

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      #1;
      checks++;
      if (busy || done || err || m_cen || m_wen || m_addr != '0) begin
        errors++;
        $display("FAIL reset_outputs got busy=%b done=%b err=%b cen=%b wen=%b addr=%0d want all 0",
                 busy, done, err, m_cen, m_wen, m_addr);
      end
    end else begin
      acc_t a;
      ev_t x;
      bit want;
      int g;
      while (aq.size() > 0 && aq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_access cyc=%0d got none want addr=%0d wen=%b", aq[0].cyc, aq[0].addr,
                 aq[0].wen);
        void'(aq.pop_front());
      end
      want = aq.size() > 0 && aq[0].cyc == cyc;
      checks++;
      if (busy !== want) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, want);
      end
      checks++;
      if (m_cen !== want) begin
        errors++;
        $display("FAIL access_presence cyc=%0d got cen=%b want %b", cyc, m_cen, want);
      end
      if (want) begin
        a = aq.pop_front();
        if (m_cen === 1'b1) begin
          checks++;
          if (m_wen !== a.wen || m_addr !== a.addr || (a.wen && m_din !== a.data)) begin
            errors++;
            $display("FAIL access cyc=%0d got wen=%b addr=%0d din=%h want wen=%b addr=%0d din=%h",
                     cyc, m_wen, m_addr, m_din, a.wen, a.addr, a.data);
          end
        end
      end
      while (eq.size() > 0 && eq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event cyc=%0d got none want kind=%0d", eq[0].cyc, eq[0].kind);
        void'(eq.pop_front());
      end
      g = (done ? 1 : 0) + (err ? 2 : 0);
      if (g != 0) begin
        checks++;
        if (eq.size() > 0 && eq[0].cyc == cyc) begin
          x = eq.pop_front();
          if (g != x.kind) begin
            errors++;
            $display("FAIL event_kind cyc=%0d got %0d want %0d", cyc, g, x.kind);
          end
        end else begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got kind=%0d want none", cyc, g);
        end
        for (int i = 0; i < 32; i++) begin
          checks++;
          if (mem[i] !== mdl[i]) begin
            errors++;
            $display("FAIL ram[%0d] cyc=%0d got %h want %h", i, cyc, mem[i], mdl[i]);
          end
        end
      end else if (eq.size() > 0 && eq[0].cyc == cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event cyc=%0d got none want kind=%0d", cyc, eq[0].kind);
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    int c0;
    #2 reset_n = 1'b0;
    #10 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    cmd(1'b0, 0, 0, 32, 32'h0, 1'b0);
    cmd(1'b0, 0, 30, 4, 32'hA5A5_0001, 1'b0);
    for (int i = 0; i < 32; i++) cmd(1'b0, 0, i, 1, 32'h100 + 32'(i), 1'b0);
    cmd(1'b1, 2, 10, 3, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cmd(1'b0, 0, i, 1, 32'(i + 1), 1'b0);
    cmd(1'b1, 0, 1, 3, 32'h0, 1'b0);
    cmd(1'b0, 0, 7, 0, 32'hDEAD_BEEF, 1'b0);
    cmd(1'b1, 3, 7, 40, 32'hDEAD_BEEF, 1'b0);
    cmd(1'b1, 20, 5, 4, 32'h0, 1'b1);
    cmd(1'b0, 0, 31, 32, 32'h1234_5678, 1'b1);
    cmd(1'b1, 28, 30, 6, 32'h0, 1'b0);
    for (int n = 0; n < 25; n++)
      cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 40)), $urandom, 1'b0);
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      push_acc(c0 + 2 * k, 1'b0, k, '0);
      if (k < 2) begin
        mdl[16 + k] = mdl[k];
        push_acc(c0 + 2 * k + 1, 1'b1, 16 + k, mdl[k]);
      end
    end
    op = 1'b1;
    src_addr = 5'd0;
    dst_addr = 5'd16;
    len = 6'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 4) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    cmd(1'b0, 0, 3, 5, 32'hCAFE_F00D, 1'b0);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
